// File: rtl/accel_rf_pkg.sv
// Shared constants and types for the accelerator register file.
package accel_rf_pkg;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefDepth = 48;

  typedef enum logic {StIdle, StClear} clr_state_e;

endpackage

// File: rtl/accel_rf_clear_seq.sv
// Clear sequencer: sweeps every register index once, one entry per cycle.
module accel_rf_clear_seq
  import accel_rf_pkg::*;
#(
  parameter int unsigned DEPTH          = DefDepth,
  parameter int unsigned ADDR_W         = 6,
  parameter bit          CLEAR_ON_RESET = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_req_i,
  output logic              busy_o,
  output logic              clr_en_o,
  output logic [ADDR_W-1:0] clr_idx_o
);

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

  clr_state_e        state_q;
  logic [ADDR_W-1:0] idx_q;
  logic              auto_q;  // sweep owed once reset releases

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      idx_q   <= '0;
      auto_q  <= CLEAR_ON_RESET;
    end else begin
      case (state_q)
        StIdle: begin
          if (clear_req_i || auto_q) begin
            state_q <= StClear;
            idx_q   <= '0;
            auto_q  <= 1'b0;
          end
        end
        StClear: begin
          if (idx_q == LastIdx) begin
            state_q <= StIdle;
            idx_q   <= '0;
          end else begin
            idx_q <= idx_q + ADDR_W'(1);
          end
        end
      endcase
    end
  end

  assign busy_o    = (state_q == StClear);
  assign clr_en_o  = (state_q == StClear);
  assign clr_idx_o = idx_q;

endmodule

// File: rtl/accel_reg_file.sv
// Register file with a byte-strobed host port, a full-word accelerator port,
// write-first combinational reads and a hardware clear sweep.
module accel_reg_file
  import accel_rf_pkg::*;
#(
  parameter int unsigned DATA_W         = DefDataW,
  parameter int unsigned DEPTH          = DefDepth,
  parameter int unsigned NUM_RD         = 2,
  parameter bit          CLEAR_ON_RESET = 1'b0,
  localparam int unsigned ADDR_W        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned STRB_W        = DATA_W / 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_RD*ADDR_W-1:0] read_reg_i,
  output logic [NUM_RD*DATA_W-1:0] read_data_o,
  input  logic                     reg_write_i,
  input  logic [ADDR_W-1:0]        write_reg_i,
  input  logic [DATA_W-1:0]        write_data_i,
  input  logic [STRB_W-1:0]        write_strb_i,
  input  logic                     acc_write_i,
  input  logic [ADDR_W-1:0]        acc_reg_i,
  input  logic [DATA_W-1:0]        acc_data_i,
  input  logic                     clear_req_i,
  output logic                     busy_o,
  output logic                     acc_conflict_o
);

  logic              busy;
  logic              clr_en;
  logic [ADDR_W-1:0] clr_idx;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              host_ok;
  logic              acc_req;
  logic              acc_ok;
  logic              conflict;
  logic              acc_conflict_q;
  logic [DATA_W-1:0] host_word;

  function automatic logic in_range(logic [ADDR_W-1:0] addr);
    return 32'(addr) < DEPTH;
  endfunction

  accel_rf_clear_seq #(
    .DEPTH          (DEPTH),
    .ADDR_W         (ADDR_W),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_req_i (clear_req_i),
    .busy_o      (busy),
    .clr_en_o    (clr_en),
    .clr_idx_o   (clr_idx)
  );

  // Host wins same-address collisions; the accelerator word is dropped whole.
  always_comb begin
    host_ok   = reg_write_i && !busy && in_range(write_reg_i);
    acc_req   = acc_write_i && !busy && in_range(acc_reg_i);
    conflict  = host_ok && acc_req && (write_reg_i == acc_reg_i);
    acc_ok    = acc_req && !conflict;
    host_word = host_ok ? mem_q[write_reg_i] : '0;
    for (int b = 0; b < int'(STRB_W); b++) begin
      if (write_strb_i[b]) host_word[8*b +: 8] = write_data_i[8*b +: 8];
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_en) begin
      mem_q[clr_idx] <= '0;
    end else begin
      if (host_ok) mem_q[write_reg_i] <= host_word;
      if (acc_ok)  mem_q[acc_reg_i]   <= acc_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) acc_conflict_q <= 1'b0;
    else       acc_conflict_q <= conflict;
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rdata;

    assign addr = read_reg_i[p*ADDR_W +: ADDR_W];

    always_comb begin
      rdata = '0;
      if (in_range(addr)) begin
        rdata = mem_q[addr];
        if (host_ok && addr == write_reg_i)   rdata = host_word;
        else if (acc_ok && addr == acc_reg_i) rdata = acc_data_i;
      end
    end

    assign read_data_o[p*DATA_W +: DATA_W] = rdata;
  end

  assign busy_o         = busy;
  assign acc_conflict_o = acc_conflict_q;

endmodule

// File: tb/tb_accel_reg_file.sv
// Directed bench for accel_reg_file: strobes, collisions, bypass, clear sweeps.
module tb_accel_reg_file;

  logic        clk = 1'b0;
  logic        rst1, rst2;
  logic [11:0] rd_addr, rd_addr2;
  logic [63:0] rd_data, rd_data2;
  logic        reg_write, acc_write, clear_req;
  logic [5:0]  write_reg, acc_reg;
  logic [31:0] write_data, acc_data;
  logic [3:0]  strb;
  logic        busy1, conf1, busy2, conf2;
  logic        z1 = 1'b0;
  logic [5:0]  z6 = '0;
  logic [31:0] z32 = '0;
  logic [3:0]  z4 = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  accel_reg_file u_dut (
    .clk_i          (clk),
    .rst_i          (rst1),
    .read_reg_i     (rd_addr),
    .read_data_o    (rd_data),
    .reg_write_i    (reg_write),
    .write_reg_i    (write_reg),
    .write_data_i   (write_data),
    .write_strb_i   (strb),
    .acc_write_i    (acc_write),
    .acc_reg_i      (acc_reg),
    .acc_data_i     (acc_data),
    .clear_req_i    (clear_req),
    .busy_o         (busy1),
    .acc_conflict_o (conf1)
  );

  accel_reg_file #(.CLEAR_ON_RESET(1'b1)) u_dut_cor (
    .clk_i          (clk),
    .rst_i          (rst2),
    .read_reg_i     (rd_addr2),
    .read_data_o    (rd_data2),
    .reg_write_i    (z1),
    .write_reg_i    (z6),
    .write_data_i   (z32),
    .write_strb_i   (z4),
    .acc_write_i    (z1),
    .acc_reg_i      (z6),
    .acc_data_i     (z32),
    .clear_req_i    (z1),
    .busy_o         (busy2),
    .acc_conflict_o (conf2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr = {6'(a1), 6'(a0)};
  endtask

  task automatic host(input int a, input logic [31:0] d, input logic [3:0] s);
    reg_write = 1'b1; write_reg = 6'(a); write_data = d; strb = s;
  endtask

  task automatic acc(input int a, input logic [31:0] d);
    acc_write = 1'b1; acc_reg = 6'(a); acc_data = d;
  endtask

  task automatic no_wr();
    reg_write = 1'b0; acc_write = 1'b0;
  endtask

  initial begin
    int cnt;
    logic first;
    rst1 = 1'b1; rst2 = 1'b1; rd_addr = '0; rd_addr2 = '0;
    reg_write = 1'b0; acc_write = 1'b0; clear_req = 1'b0;
    write_reg = '0; acc_reg = '0; write_data = '0; acc_data = '0; strb = '0;
    repeat (3) tick();
    @(negedge clk);
    check_eq("rst_busy", 32'(busy1), 32'd0);
    check_eq("rst_conflict", 32'(conf1), 32'd0);
    check_eq("rst_busy_cor", 32'(busy2), 32'd0);

    // Release reset; the CLEAR_ON_RESET instance must sweep on its own.
    tick();
    rst1 = 1'b0; rst2 = 1'b0;
    cnt = 0; first = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (i == 0) first = busy2;
      if (busy2) cnt++;
    end
    check_eq("cor_busy_rise", 32'(first), 32'd1);
    check_eq("cor_busy_cycles", 32'(cnt), 32'd48);
    check_eq("no_auto_clear", 32'(busy1), 32'd0);
    rd_addr2 = {6'd47, 6'd0};
    #1;
    check_eq("cor_reg0", rd_data2[31:0], 32'h0);
    check_eq("cor_reg47", rd_data2[63:32], 32'h0);

    // Byte-strobe merge, with bypass of the merged word.
    host(5, 32'hDEADBEEF, 4'hF); tick();
    host(5, 32'h0000AA00, 4'h2); set_rd(5, 5);
    @(negedge clk);
    check_eq("strb_bypass", rd_data[31:0], 32'hDEADAAEF);
    tick(); no_wr(); #1;
    check_eq("strb_merge", rd_data[31:0], 32'hDEADAAEF);
    host(5, 32'h0, 4'h0);
    @(negedge clk);
    check_eq("strb0_bypass", rd_data[31:0], 32'hDEADAAEF);
    tick(); no_wr(); #1;
    check_eq("strb0_keep", rd_data[31:0], 32'hDEADAAEF);

    // Same-address collision: host wins, one-cycle conflict pulse.
    host(7, 32'h11111111, 4'hF); acc(7, 32'h22222222); set_rd(7, 7);
    @(negedge clk);
    check_eq("coll_bypass", rd_data[63:32], 32'h11111111);
    check_eq("coll_conf_early", 32'(conf1), 32'd0);
    tick(); no_wr(); #1;
    check_eq("coll_conf", 32'(conf1), 32'd1);
    check_eq("coll_value", rd_data[31:0], 32'h11111111);
    tick();
    check_eq("coll_conf_end", 32'(conf1), 32'd0);

    // Different addresses in one cycle both commit.
    host(8, 32'hA5A5A5A5, 4'hF); acc(9, 32'h5A5A5A5A); set_rd(8, 9);
    @(negedge clk);
    check_eq("dual_bypass_h", rd_data[31:0], 32'hA5A5A5A5);
    check_eq("dual_bypass_a", rd_data[63:32], 32'h5A5A5A5A);
    tick(); no_wr(); #1;
    check_eq("dual_host", rd_data[31:0], 32'hA5A5A5A5);
    check_eq("dual_acc", rd_data[63:32], 32'h5A5A5A5A);
    check_eq("dual_no_conf", 32'(conf1), 32'd0);

    host(3, 32'h12345678, 4'hF); set_rd(0, 3);
    @(negedge clk);
    check_eq("bypass_host_p1", rd_data[63:32], 32'h12345678);
    tick(); no_wr();
    acc(10, 32'hCAFEF00D); set_rd(10, 3);
    @(negedge clk);
    check_eq("bypass_acc_p0", rd_data[31:0], 32'hCAFEF00D);
    check_eq("stored_reg3", rd_data[63:32], 32'h12345678);
    tick(); no_wr();

    // Populate every entry: host on even, accelerator on odd.
    for (int k = 0; k < 24; k++) begin
      host(2 * k, 32'hA000_0000 + 32'(2 * k), 4'hF);
      acc(2 * k + 1, 32'hA000_0000 + 32'(2 * k + 1));
      tick();
    end
    no_wr();

    // Out-of-range writes are ignored and out-of-range reads return zero.
    host(50, 32'hFFFFFFFF, 4'hF); acc(50, 32'hFFFFFFFF); set_rd(50, 50);
    @(negedge clk);
    check_eq("oob_rd_bypass", rd_data[31:0], 32'h0);
    tick(); no_wr(); #1;
    check_eq("oob_no_conf", 32'(conf1), 32'd0);
    for (int k = 0; k < 24; k++) begin
      set_rd(2 * k, 2 * k + 1); #1;
      check_eq($sformatf("pop_reg%0d", 2 * k), rd_data[31:0], 32'hA000_0000 + 32'(2 * k));
      check_eq($sformatf("pop_reg%0d", 2 * k + 1), rd_data[63:32],
               32'hA000_0000 + 32'(2 * k + 1));
    end
    set_rd(50, 63); #1;
    check_eq("oob_rd50", rd_data[31:0], 32'h0);
    check_eq("oob_rd63", rd_data[63:32], 32'h0);

    // Clear sweep: writes, conflicts and re-requests during busy have no effect.
    tick();
    clear_req = 1'b1; tick(); clear_req = 1'b0;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (i == 0) check_eq("clr_busy_rise", 32'(busy1), 32'd1);
      if (busy1) cnt++;
      if (i == 5) begin host(47, 32'hFFFFFFFF, 4'hF); acc(47, 32'hEEEEEEEE); set_rd(47, 46); end
      if (i == 6) no_wr();
      if (i == 10) clear_req = 1'b1;
      if (i == 11) clear_req = 1'b0;
      if (i == 20) begin host(3, 32'hFFFFFFFF, 4'hF); acc(4, 32'hEEEEEEEE); set_rd(3, 4); end
      if (i == 21) no_wr();
      @(negedge clk);
      if (i == 5) begin
        check_eq("busy_no_bypass47", rd_data[31:0], 32'hA000_002F);
        check_eq("busy_stored46", rd_data[63:32], 32'hA000_002E);
      end
      if (i == 6) check_eq("busy_no_conf", 32'(conf1), 32'd0);
      if (i == 20) begin
        check_eq("busy_rd3", rd_data[31:0], 32'h0);
        check_eq("busy_rd4", rd_data[63:32], 32'h0);
      end
      tick();
    end
    check_eq("clr_busy_cycles", 32'(cnt), 32'd48);
    for (int k = 0; k < 24; k++) begin
      set_rd(2 * k, 2 * k + 1); #1;
      check_eq($sformatf("clr_reg%0d", 2 * k), rd_data[31:0], 32'h0);
      check_eq($sformatf("clr_reg%0d", 2 * k + 1), rd_data[63:32], 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
